// File: rtl/lbist_sig_checker_pkg.sv
// Shared LBIST checker constants: MISR geometry, golden signature and FSM state encoding.
package lbist_sig_checker_pkg;

  localparam int LBIST_N_MISR = 10;
  localparam int LBIST_MISR_W = 24;
  localparam logic [LBIST_N_MISR*LBIST_MISR_W-1:0] LBIST_GOLDEN_SIG =
    {(LBIST_N_MISR*LBIST_MISR_W){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMP  = 2'b01,
    ST_DONE = 2'b10
  } chk_state_e;

endpackage

// File: rtl/lbist_sig_checker.sv
// Snapshots the MISR signature bus on request and compares it against the golden
// signature one slice per cycle, reporting pass/fail, mismatch mask and first failing index.
module lbist_sig_checker
  import lbist_sig_checker_pkg::*;
#(
  parameter int                   N_MISR = LBIST_N_MISR,
  parameter int                   W      = LBIST_MISR_W,
  parameter logic [N_MISR*W-1:0]  GOLDEN = LBIST_GOLDEN_SIG
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [N_MISR*W-1:0]         sig_in,
  input  logic [$clog2(N_MISR)-1:0]   rd_sel,
  output logic [W-1:0]                rd_sig,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [N_MISR-1:0]           fail_mask,
  output logic [$clog2(N_MISR)-1:0]   first_fail
);

  localparam int IW = $clog2(N_MISR);

  chk_state_e           state_r;
  chk_state_e           state_nxt_s;
  logic [N_MISR*W-1:0]  snapshot_r;
  logic [IW-1:0]        idx_r;
  logic [N_MISR-1:0]    fail_mask_r;
  logic [IW-1:0]        first_fail_r;
  logic [W-1:0]         cmp_slice_s;
  logic [W-1:0]         gold_slice_s;
  logic                 mismatch_s;
  logic                 last_idx_s;
  logic                 arm_s;

  // Single W-bit comparator shared across all slices via the running index.
  always_comb begin
    cmp_slice_s  = snapshot_r[W*idx_r +: W];
    gold_slice_s = GOLDEN[W*idx_r +: W];
    mismatch_s   = (state_r == ST_CMP) && (cmp_slice_s != gold_slice_s);
    last_idx_s   = (int'(idx_r) == (N_MISR - 1));
    arm_s        = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_CMP;
        else       state_nxt_s = ST_IDLE;
      end
      ST_CMP: begin
        if (last_idx_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_CMP;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_CMP;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, snapshot and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      snapshot_r   <= {(N_MISR*W){1'b0}};
      idx_r        <= {IW{1'b0}};
      fail_mask_r  <= {N_MISR{1'b0}};
      first_fail_r <= {IW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (arm_s) begin
        snapshot_r   <= sig_in;
        idx_r        <= {IW{1'b0}};
        fail_mask_r  <= {N_MISR{1'b0}};
        first_fail_r <= {IW{1'b0}};
      end else if (state_r == ST_CMP) begin
        // Only the first hit records an index, so the lowest failing slice wins.
        if (mismatch_s) begin
          fail_mask_r[idx_r] <= 1'b1;
          if (fail_mask_r == {N_MISR{1'b0}}) first_fail_r <= idx_r;
        end
        if (!last_idx_s) idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Debug readback of the captured signature; out-of-range selects read zero.
  always_comb begin
    if (int'(rd_sel) < N_MISR) rd_sig = snapshot_r[W*rd_sel +: W];
    else                       rd_sig = {W{1'b0}};
  end

  assign busy       = (state_r == ST_CMP);
  assign done       = (state_r == ST_DONE);
  assign pass       = done && (fail_mask_r == {N_MISR{1'b0}});
  assign fail_mask  = fail_mask_r;
  assign first_fail = first_fail_r;

endmodule

// File: tb/tb_lbist_sig_checker.sv
// Scoreboard bench for lbist_sig_checker: directed scenarios plus randomized signatures.
module tb_lbist_sig_checker;

  localparam int N = 10;
  localparam int W = 24;
  localparam logic [239:0] GOLD = {24'h13579B, 24'h2468AC, 24'hDEADBE, 24'h0F1E2D, 24'hC0FFEE,
                                   24'h5A5A5A, 24'h777001, 24'hABCDEF, 24'h800001, 24'h3C3C3C};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [239:0] sig_in;
  logic [3:0]   rd_sel;
  logic [23:0]  rd_sig;
  logic         busy, done, pass;
  logic [9:0]   fail_mask;
  logic [3:0]   first_fail;

  typedef struct {
    logic [9:0] mask;
    logic [3:0] first;
    logic       pass;
    int         done_cyc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [239:0] snap_m;
  logic         done_prev = 1'b0;

  lbist_sig_checker #(.N_MISR(N), .W(W), .GOLDEN(GOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_in(sig_in), .rd_sel(rd_sel),
    .rd_sig(rd_sig), .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .first_fail(first_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [239:0] act, input logic [239:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: slice-by-slice equality against the golden vector, lowest index reported.
  function automatic exp_t model(input logic [239:0] s, input int dc);
    exp_t e;
    e.mask = 10'h000;
    e.first = 4'd0;
    e.done_cyc = dc;
    for (int i = N - 1; i >= 0; i--) begin
      if (s[i*W +: W] != GOLD[i*W +: W]) begin
        e.mask[i] = 1'b1;
        e.first = 4'(i);
      end
    end
    e.pass = (e.mask == 10'h000);
    return e;
  endfunction

  // Monitor: every rising edge of done must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_latency", 240'(cyc), 240'(mon_e.done_cyc));
        chk("pass", 240'(pass), 240'(mon_e.pass));
        chk("fail_mask", 240'(fail_mask), 240'(mon_e.mask));
        chk("first_fail", 240'(first_fail), 240'(mon_e.first));
      end
    end
    done_prev = done;
  end

  // Present start for one sampling edge; returns just after that edge.
  task automatic issue(input logic [239:0] s, input bit push);
    @(posedge clk); #1;
    sig_in = s;
    start  = 1'b1;
    snap_m = s;
    if (push) sb_q.push_back(model(s, cyc + 11));
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_in_cmp", 240'(busy), 240'(1'b1));
  endtask

  task automatic full_check(input logic [239:0] s, input bit sweep);
    issue(s, 1'b1);
    sig_in = 240'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    repeat (10) @(posedge clk);
    #1;
    if (sweep) begin
      for (int i = 0; i < 16; i++) begin
        rd_sel = 4'(i);
        #1;
        chk("rd_sig", 240'(rd_sig), (i < N) ? 240'(snap_m[i*W +: W]) : 240'(0));
      end
    end
  endtask

  logic [239:0] s_v;
  int           tmo;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    sig_in = 240'(0);
    rd_sel = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 240'(busy), 240'(0));
    chk("rst_done", 240'(done), 240'(0));
    chk("rst_pass", 240'(pass), 240'(0));
    chk("rst_fail_mask", 240'(fail_mask), 240'(0));
    chk("rst_first_fail", 240'(first_fail), 240'(0));
    chk("rst_rd_sig", 240'(rd_sig), 240'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: golden match
    full_check(GOLD, 1'b1);
    // 2: bit 77 in slice 3
    s_v = GOLD; s_v[77] = ~s_v[77];
    full_check(s_v, 1'b0);
    // 3: bits 0 and 239, then read slice 9 back
    s_v = GOLD; s_v[0] = ~s_v[0]; s_v[239] = ~s_v[239];
    full_check(s_v, 1'b0);
    rd_sel = 4'd9; #1;
    chk("rd_sig_slice9", 240'(rd_sig), 240'(s_v[239:216]));

    // 6: re-arm from a failing DONE; done must stay low while comparing
    issue(GOLD, 1'b1);
    repeat (9) begin
      chk("done_low_rearm", 240'(done), 240'(0));
      @(posedge clk); #1;
    end
    @(posedge clk); #1;

    // 4: sig_in change and stray start while comparing
    s_v = GOLD; s_v[130] = ~s_v[130];
    issue(s_v, 1'b1);
    sig_in = GOLD;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // 5: reset in the middle of a compare
    s_v = GOLD; s_v[5] = ~s_v[5];
    issue(s_v, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_sel = 4'd0;
    @(negedge clk);
    chk("midrst_busy", 240'(busy), 240'(0));
    chk("midrst_done", 240'(done), 240'(0));
    chk("midrst_pass", 240'(pass), 240'(0));
    chk("midrst_fail_mask", 240'(fail_mask), 240'(0));
    chk("midrst_first_fail", 240'(first_fail), 240'(0));
    chk("midrst_rd_sig", 240'(rd_sig), 240'(0));
    full_check(GOLD, 1'b0);

    // start held high: back-to-back checks, one per pass through DONE
    s_v = GOLD; s_v[200] = ~s_v[200]; s_v[60] = ~s_v[60];
    @(posedge clk); #1;
    sig_in = s_v;
    start  = 1'b1;
    for (int j = 0; j < 3; j++) sb_q.push_back(model(s_v, cyc + 11 + 11 * j));
    repeat (33) @(posedge clk);
    #1;
    start = 1'b0;

    // randomized signatures
    for (int it = 0; it < 12; it++) begin
      s_v = GOLD;
      for (int i = 0; i < N; i++)
        if ($urandom_range(2) == 0) s_v[i*W +: W] = s_v[i*W +: W] ^ (24'($urandom) | 24'h000001);
      full_check(s_v, (it < 2) ? 1'b1 : 1'b0);
    end

    tmo = 0;
    while (sb_q.size() != 0 && tmo < 50) begin
      @(posedge clk);
      tmo++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sb_q.size());
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
